// File: rtl/cache_assoc.sv
// cache_assoc: set-associative write-through, no-write-allocate cache with blocking line fill
module cache_assoc #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int SETS        = 8,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 8
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_MemRead,
  input  logic [ADDR_W-1:0] pipe_read_addr,
  input  logic              pipe_MemWrite,
  input  logic [ADDR_W-1:0] pipe_mem_write_addr,
  input  logic [DATA_W-1:0] pipe_mem_write_data,
  input  logic              MemDataValid,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              cache_MemRead,
  output logic              cache_MemWrite,
  output logic [ADDR_W-1:0] cache_mem_addr,
  output logic [DATA_W-1:0] cache_mem_write_data,
  output logic [DATA_W-1:0] cache_data_out,
  output logic              CacheFinish,
  output logic              CacheBusy
);
  localparam int OFF = $clog2(BLOCK_WORDS) + 1;
  localparam int IDX = $clog2(SETS);
  localparam int TAG = ADDR_W - OFF - IDX;
  localparam int WB  = OFF - 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WB-1:0]     cnt_q, cnt_d;
  logic              vic_q, vic_d;
  logic [TAG-1:0]    ftag_q, ftag_d;
  logic [IDX-1:0]    fidx_q, fidx_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SETS-1:0]   lru_q, lru_d;
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   valid_d [WAYS];
  logic [TAG-1:0]    tag_q [WAYS][SETS];
  logic [DATA_W-1:0] data_q [WAYS][SETS][BLOCK_WORDS];

  logic [ADDR_W-1:0] la;
  logic [TAG-1:0]    l_tag;
  logic [IDX-1:0]    l_idx;
  logic [WB-1:0]     l_word;
  logic              hit, hit_way, victim;
  logic              dwe, dway, tag_we;
  logic [IDX-1:0]    didx;
  logic [WB-1:0]     dword;
  logic [DATA_W-1:0] dwdata;
  logic              mrd, mwr, fin, busy;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] mwdata, dout;
  logic              unused_ok;

  // Byte-select bit of word-aligned addresses carries no information
  assign unused_ok = ^{pipe_read_addr[0], pipe_mem_write_addr[0]};

  assign la     = pipe_MemWrite ? pipe_mem_write_addr : pipe_read_addr;
  assign l_tag  = la[ADDR_W-1:OFF+IDX];
  assign l_idx  = la[OFF+IDX-1:OFF];
  assign l_word = la[OFF-1:1];
  assign victim = (WAYS == 1) ? 1'b0 :
                  !valid_q[0][l_idx] ? 1'b0 :
                  !valid_q[WAYS-1][l_idx] ? 1'b1 : lru_q[l_idx];

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (!hit && valid_q[w][l_idx] && tag_q[w][l_idx] == l_tag) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vic_d   = vic_q;
    ftag_d  = ftag_q;
    fidx_d  = fidx_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    lru_d   = lru_q;
    valid_d = valid_q;
    tag_we  = 1'b0;
    dwe     = 1'b0;
    dway    = hit_way;
    didx    = l_idx;
    dword   = l_word;
    dwdata  = pipe_mem_write_data;
    mrd     = 1'b0;
    mwr     = 1'b0;
    maddr   = '0;
    mwdata  = '0;
    dout    = '0;
    fin     = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pipe_MemWrite) begin
          busy    = 1'b1;
          state_d = WRITE;
          waddr_d = pipe_mem_write_addr;
          wdata_d = pipe_mem_write_data;
          if (hit) begin
            dwe          = 1'b1;
            lru_d[l_idx] = ~hit_way;
          end
        end else if (pipe_MemRead && hit) begin
          fin          = 1'b1;
          dout         = data_q[hit_way][l_idx][l_word];
          lru_d[l_idx] = ~hit_way;
        end else if (pipe_MemRead) begin
          busy    = 1'b1;
          state_d = FILL;
          cnt_d   = '0;
          vic_d   = victim;
          ftag_d  = l_tag;
          fidx_d  = l_idx;
        end
      end
      FILL: begin
        busy  = 1'b1;
        mrd   = 1'b1;
        maddr = {ftag_q, fidx_q, cnt_q, 1'b0};
        if (MemDataValid) begin
          dwe    = 1'b1;
          dway   = vic_q;
          didx   = fidx_q;
          dword  = cnt_q;
          dwdata = mem_read_data;
          cnt_d  = cnt_q + 1'b1;
          // Line becomes visible only once its last word has landed
          if (cnt_q == WB'(BLOCK_WORDS - 1)) begin
            valid_d[vic_q][fidx_q] = 1'b1;
            tag_we                 = 1'b1;
            lru_d[fidx_q]          = ~vic_q;
            state_d                = IDLE;
          end
        end
      end
      WRITE: begin
        busy    = 1'b1;
        mwr     = 1'b1;
        maddr   = waddr_q;
        mwdata  = wdata_q;
        fin     = MemDataValid;
        state_d = MemDataValid ? IDLE : WRITE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vic_q   <= 1'b0;
      lru_q   <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vic_q   <= vic_d;
      lru_q   <= lru_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    ftag_q  <= ftag_d;
    fidx_q  <= fidx_d;
    waddr_q <= waddr_d;
    wdata_q <= wdata_d;
    if (dwe && !rst) data_q[dway][didx][dword] <= dwdata;
    if (tag_we && !rst) tag_q[vic_q][fidx_q] <= ftag_q;
  end

  assign cache_MemRead        = mrd & ~rst;
  assign cache_MemWrite       = mwr & ~rst;
  assign CacheFinish          = fin & ~rst;
  assign CacheBusy            = busy & ~rst;
  assign cache_mem_addr       = rst ? '0 : maddr;
  assign cache_mem_write_data = rst ? '0 : mwdata;
  assign cache_data_out       = rst ? '0 : dout;
endmodule

// File: doc/cache_assoc.md
CACHE_ASSOC -- requirements
Module: cache_assoc

Interface
REQ-001 The block SHALL be clocked by a single clock, with reset synchronous and active-high; no other clock or async reset exists.
REQ-002 Param DATA_W, 16, data word width; ADDR_W, 16, byte address width; words are 2-byte aligned and addr bit 0 is ignored.
REQ-003 Param SETS, 8, number of sets, power of 2 and >=2.
REQ-004 Param WAYS, 2, associativity; legal values are 1 and 2.
REQ-005 Param BLOCK_WORDS, 8, words per line, power of 2; offset=log2(BLOCK_WORDS)+1 bits, index=log2(SETS) bits, tag=remainder.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 pipe_MemRead  in  1  pipeline read request, held until CacheFinish.
REQ-009 pipe_read_addr  in  ADDR_W  read address.
REQ-010 pipe_MemWrite  in  1  pipeline write request, held until CacheFinish.
REQ-011 pipe_mem_write_addr  in  ADDR_W  write address.
REQ-012 pipe_mem_write_data  in  DATA_W  write data.
REQ-013 MemDataValid  in  1  memory strobe: read word valid or write accepted.
REQ-014 mem_read_data  in  DATA_W  word returned by memory.
REQ-015 cache_MemRead  out  1  cache requests a memory read.
REQ-016 cache_MemWrite  out  1  cache requests a memory write.
REQ-017 cache_mem_addr  out  ADDR_W  memory address for the current cache request.
REQ-018 cache_mem_write_data  out  DATA_W  write-through data.
REQ-019 cache_data_out  out  DATA_W  read data, valid when CacheFinish=1.
REQ-020 CacheFinish  out  1  one-cycle pulse marking request completion.
REQ-021 CacheBusy  out  1  cache is in FILL or WRITE, and the pipeline must stall.

Function
REQ-022 FSM states SHALL be IDLE, FILL, WRITE.
REQ-023 IDLE lookup SHALL be combinational: a read hit SHALL give CacheFinish=1 and correct cache_data_out in the same cycle, with CacheBusy=0.
REQ-024 Priority SHALL be write over read when both are asserted; the read is serviced after the write completes.
REQ-025 On a read miss, the block SHALL enter FILL next cycle and drive CacheBusy=1 in the miss cycle and throughout FILL.
REQ-026 In FILL, cache_MemRead SHALL be 1 and cache_mem_addr SHALL equal {tag,index,word_cnt,1'b0}, starting at word_cnt=0.
REQ-027 In FILL, word_cnt SHALL increment and the word SHALL be stored only on a cycle with MemDataValid=1; otherwise the address SHALL hold.
REQ-028 On the MemDataValid cycle for word BLOCK_WORDS-1, the block SHALL set the victim valid bit and tag, then return to IDLE; the re-lookup then hits.
REQ-029 The victim way SHALL be the lowest-index invalid way, or else the LRU way; with WAYS=1 it SHALL be way 0.
REQ-030 LRU (1 bit per set) SHALL mark the other way as LRU on a read hit, a write hit, or fill completion.
REQ-031 On a write, the block SHALL enter WRITE next cycle and hold cache_MemWrite=1, cache_mem_addr=write addr, and cache_mem_write_data=write data.
REQ-032 Writes SHALL be write-through: on a hit, the block SHALL update the cached word in the entry cycle.
REQ-033 Writes SHALL be no-write-allocate: a miss SHALL NOT fill or change valid, tag, or LRU.
REQ-034 WRITE SHALL exit to IDLE on MemDataValid=1, and CacheFinish SHALL pulse in that cycle.
REQ-035 cache_MemRead and cache_MemWrite SHALL never be 1 simultaneously.
REQ-036 A partially filled line SHALL never be valid.

Reset
REQ-037 With rst=1 at a clock edge, the block SHALL clear all valid bits and LRU bits, set state=IDLE and word_cnt=0, and drive all outputs to 0; this holds mid-FILL or mid-WRITE.
REQ-038 Data and tag arrays SHALL not require reset.

Verification
REQ-039 Defaults are used throughout: read 0x0004 after reset -> miss, CacheBusy=1; mem addrs 0x0000..0x000E step 2 receive data 1..8 -> CacheFinish with data_out=3; a read of 0x000E then hits with 8 and no memory read.
REQ-040 A MemDataValid gap of 2 cycles mid-fill -> cache_mem_addr holds and word_cnt does not advance; the final data is still correct.
REQ-041 Fill 0x0000 then 0x0080 (set 0, both ways); read 0x0000 hits; read 0x0100 -> evicts 0x0080; 0x0000 still hits and 0x0080 misses.
REQ-042 Write 0x0006=0xBEEF on a resident line -> cache_MemWrite with addr 0x0006 and data 0xBEEF until MemDataValid; a subsequent read of 0x0006 hits with 0xBEEF.
REQ-043 Write 0x0200 on a miss -> one memory write and no fill; a subsequent read of 0x0200 misses.
REQ-044 rst after 3 fill words -> outputs 0; re-reading 0x0004 misses and refetches from 0x0000.
